// File: rtl/puf_response_voter.sv
// puf_response_voter
// Majority-vote stabiliser in front of a memristive PUF core. For each accepted
// challenge the PUF is reset, driven with the challenge for a settle window and
// sampled N_VOTE times. The voter then returns the per-bit majority response,
// a mask of bits whose votes disagreed, and an echo of the challenge.

module puf_response_voter #(
  parameter int N_CHAL     = 8,
  parameter int N_RESP     = 8,
  parameter int N_VOTE     = 5,
  parameter int SETTLE_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [N_CHAL-1:0] req_chal,
  output logic              puf_rst_n,
  output logic              puf_vin_valid,
  output logic [N_CHAL-1:0] puf_C,
  input  logic [N_RESP-1:0] puf_R,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [N_RESP-1:0] rsp_resp,
  output logic [N_RESP-1:0] rsp_unstable,
  output logic [N_CHAL-1:0] rsp_chal
);

  // Vote counters hold 0..N_VOTE; the phase timer spans both the 2-cycle PUF
  // reset and the settle window.
  localparam int CW = $clog2(N_VOTE + 1);
  localparam int TW = $clog2(SETTLE_CYC + 2);

  typedef enum logic [2:0] {
    IDLE,
    PRST,
    APPLY,
    SAMPLE,
    DONE
  } state_t;

  state_t            state;
  logic [TW-1:0]     timer;
  logic [CW-1:0]     votes;
  logic [CW-1:0]     cnt1 [N_RESP];
  logic [N_CHAL-1:0] chal_q;

  // Ones-counts including the sample taken at the end of SAMPLE, so the final
  // vote lands in the registered response on the same edge that enters DONE.
  logic [CW-1:0]     cnt_next [N_RESP];
  logic [N_RESP-1:0] maj_next;
  logic [N_RESP-1:0] unstable_next;

  // Per-bit next counts and the majority/unanimity decisions derived from them.
  always_comb begin
    // NOTE: every output of this block is assigned on every pass through the
    // loop, so no storage (latch) can be inferred.
    for (int i = 0; i < N_RESP; i++) begin
      cnt_next[i]      = cnt1[i] + CW'(puf_R[i]);
      maj_next[i]      = cnt_next[i] > CW'(N_VOTE / 2);
      unstable_next[i] = (cnt_next[i] != '0) && (cnt_next[i] != CW'(N_VOTE));
    end
  end

  // Sequencer: PUF reset, settle, sample, repeated N_VOTE times, then hold the
  // result until downstream accepts it. All outputs are registered here.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state         <= IDLE;
      timer         <= '0;
      votes         <= '0;
      chal_q        <= '0;
      req_ready     <= 1'b1;
      puf_rst_n     <= 1'b0;
      puf_vin_valid <= 1'b0;
      puf_C         <= '0;
      rsp_valid     <= 1'b0;
      rsp_resp      <= '0;
      rsp_unstable  <= '0;
      rsp_chal      <= '0;
      // NOTE: the counter array is a handful of flops, not a RAM, so it is
      // reset explicitly; an aborted run must never leak counts forward.
      for (int i = 0; i < N_RESP; i++) cnt1[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          puf_rst_n     <= 1'b1;
          puf_vin_valid <= 1'b0;
          if (req_valid && req_ready) begin
            chal_q    <= req_chal;
            puf_C     <= req_chal;
            votes     <= '0;
            timer     <= '0;
            req_ready <= 1'b0;
            puf_rst_n <= 1'b0;
            for (int i = 0; i < N_RESP; i++) cnt1[i] <= '0;
            state     <= PRST;
          end
        end

        PRST: begin
          if (timer == TW'(1)) begin
            timer         <= '0;
            puf_rst_n     <= 1'b1;
            puf_vin_valid <= 1'b1;
            state         <= APPLY;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        APPLY: begin
          if (timer == TW'(SETTLE_CYC - 1)) begin
            timer <= '0;
            state <= SAMPLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        SAMPLE: begin
          for (int i = 0; i < N_RESP; i++) cnt1[i] <= cnt_next[i];
          votes         <= votes + 1'b1;
          puf_vin_valid <= 1'b0;
          if (votes == CW'(N_VOTE - 1)) begin
            rsp_valid    <= 1'b1;
            rsp_resp     <= maj_next;
            rsp_unstable <= unstable_next;
            rsp_chal     <= chal_q;
            state        <= DONE;
          end else begin
            puf_rst_n <= 1'b0;
            state     <= PRST;
          end
        end

        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_response_voter.sv
// Bench for puf_response_voter: a default instance (5 votes, 16-cycle settle)
// driven by a noisy PUF model, plus a 1-vote / 1-cycle-settle instance.
// Expected responses are queued when a request is driven and compared when
// the voter presents its result.

module tb_puf_response_voter;

  localparam int LAT   = 5 * (16 + 3);
  localparam int LAT_B = 1 * (1 + 3);

  typedef struct {
    logic [7:0] resp;
    logic [7:0] unst;
    logic [7:0] chal;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default instance signals
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_chal = 8'h00;
  logic       puf_rst_n, puf_vin_valid;
  logic [7:0] puf_c, puf_r;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_resp, rsp_unstable, rsp_chal;

  // Single-vote instance signals
  logic       req_valid_b = 1'b0;
  logic       req_ready_b;
  logic [7:0] req_chal_b = 8'h00;
  logic       puf_rst_n_b, puf_vin_valid_b;
  logic [7:0] puf_c_b, puf_r_b;
  logic       rsp_valid_b;
  logic       rsp_ready_b = 1'b1;
  logic [7:0] rsp_resp_b, rsp_unstable_b, rsp_chal_b;

  puf_response_voter #(.N_CHAL(8), .N_RESP(8), .N_VOTE(5), .SETTLE_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_chal(req_chal),
    .puf_rst_n(puf_rst_n), .puf_vin_valid(puf_vin_valid), .puf_C(puf_c), .puf_R(puf_r),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resp(rsp_resp),
    .rsp_unstable(rsp_unstable), .rsp_chal(rsp_chal)
  );

  puf_response_voter #(.N_CHAL(8), .N_RESP(8), .N_VOTE(1), .SETTLE_CYC(1)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_chal(req_chal_b),
    .puf_rst_n(puf_rst_n_b), .puf_vin_valid(puf_vin_valid_b), .puf_C(puf_c_b), .puf_R(puf_r_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_resp(rsp_resp_b),
    .rsp_unstable(rsp_unstable_b), .rsp_chal(rsp_chal_b)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  // PUF models: R = C ^ 5A with an optional per-vote flip mask (votes 1..5).
  logic [7:0] flip [8];
  logic [7:0] noise_b = 8'h00;
  int         vote_total = 0;
  int         vote_base  = 0;

  always_comb puf_r   = puf_c ^ 8'h5A ^ flip[3'(vote_total - vote_base)];
  always_comb puf_r_b = puf_c_b ^ noise_b;

  // Monitor of puf_rst_n low pulses: counts vote starts and pulse lengths.
  int   pulse_len  = 0;
  int   pulse_good = 0;
  int   pulse_bad  = 0;
  logic last_rst_n = 1'b1;
  always @(negedge clk) begin
    if (!puf_rst_n) begin
      if (last_rst_n) vote_total++;
      pulse_len++;
      if (puf_vin_valid) pulse_bad++;
    end else if (!last_rst_n) begin
      if (pulse_len == 2) pulse_good++;
      else pulse_bad++;
      pulse_len = 0;
    end
    last_rst_n = puf_rst_n;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference majority over the five modelled votes.
  function automatic exp_t model(input logic [7:0] c);
    exp_t       e;
    logic [7:0] r;
    int         n;
    e.chal = c;
    for (int b = 0; b < 8; b++) begin
      n = 0;
      for (int v = 1; v <= 5; v++) begin
        r = c ^ 8'h5A ^ flip[v];
        n += int'(r[b]);
      end
      e.resp[b] = (n > 2);
      e.unst[b] = (n != 0) && (n != 5);
    end
    return e;
  endfunction

  task automatic set_flips(input logic [7:0] f1, f2, f3, f4, f5);
    for (int i = 0; i < 8; i++) flip[i] = 8'h00;
    flip[1] = f1; flip[2] = f2; flip[3] = f3; flip[4] = f4; flip[5] = f5;
  endtask

  // One request on the default instance. bp: cycles of rsp_ready=0 after
  // rsp_valid; inject: late request during vote 3 APPLY; abort: rst in vote 4 SAMPLE.
  task automatic run_req(input logic [7:0] c, input int bp, input bit inject, input bit abort);
    exp_t e;
    int   cyc;
    int   good0, bad0, bp_bad;
    bit   seen;
    @(negedge clk);
    req_chal  = c;
    req_valid = 1'b1;
    cyc = 0;
    while (!req_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("accept_ready", req_ready, 1);
    vote_base = vote_total;
    good0     = pulse_good;
    bad0      = pulse_bad;
    if (!abort) sb.push_back(model(c));
    @(negedge clk);
    req_valid = 1'b0;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < LAT + 40) begin
      if (rsp_valid) begin
        seen = 1'b1;
      end else begin
        if (inject && cyc == 45) begin
          check("inject_req_ready", req_ready, 0);
          req_chal  = 8'h3C;
          req_valid = 1'b1;
        end
        if (inject && cyc == 46) req_valid = 1'b0;
        if (inject && cyc == 50) check("inject_puf_c", puf_c, c);
        if (abort && cyc == 75) begin
          check("abort_in_sample", puf_vin_valid, 1);
          rst = 1'b1;
        end
        if (abort && cyc == 76) begin
          check("abort_outputs",
                {puf_rst_n, puf_vin_valid, rsp_valid, puf_c, rsp_resp, rsp_unstable, rsp_chal},
                64'd0);
          rst = 1'b0;
        end
        if (abort && cyc == 77) check("abort_idle", {req_ready, puf_rst_n}, 2'b11);
        @(negedge clk);
        cyc++;
      end
    end
    if (abort) begin
      check("abort_no_rsp", seen, 0);
      return;
    end
    check("latency", cyc, LAT);
    e = (sb.size() > 0) ? sb.pop_front() : '{8'hxx, 8'hxx, 8'hxx};
    check("rsp_resp", rsp_resp, e.resp);
    check("rsp_unstable", rsp_unstable, e.unst);
    check("rsp_chal", rsp_chal, e.chal);
    check("done_req_ready", req_ready, 0);
    check("done_puf_pins", {puf_rst_n, puf_vin_valid}, 2'b10);
    check("rst_pulses_2cyc", pulse_good - good0, 5);
    check("rst_pulses_bad", pulse_bad - bad0, 0);
    if (bp > 0) begin
      bp_bad = 0;
      for (int i = 0; i < bp; i++) begin
        @(negedge clk);
        if (rsp_valid !== 1'b1 || rsp_resp !== e.resp || rsp_unstable !== e.unst ||
            rsp_chal !== e.chal || req_ready !== 1'b0) bp_bad++;
      end
      check("backpressure_hold", bp_bad, 0);
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    check("hs_rsp_valid", rsp_valid, 0);
    check("hs_req_ready", req_ready, 1);
  endtask

  // One request on the single-vote instance.
  task automatic run_b(input logic [7:0] c, input logic [7:0] noise);
    exp_t e;
    int   cyc;
    @(negedge clk);
    noise_b     = noise;
    req_chal_b  = c;
    req_valid_b = 1'b1;
    cyc = 0;
    while (!req_ready_b && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    sb.push_back('{c ^ noise, 8'h00, c});
    @(negedge clk);
    req_valid_b = 1'b0;
    cyc = 0;
    while (!rsp_valid_b && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("b_latency", cyc, LAT_B);
    e = (sb.size() > 0) ? sb.pop_front() : '{8'hxx, 8'hxx, 8'hxx};
    check("b_rsp_resp", rsp_resp_b, e.resp);
    check("b_rsp_unstable", rsp_unstable_b, e.unst);
    check("b_rsp_chal", rsp_chal_b, e.chal);
    @(negedge clk);
    check("b_hs_req_ready", {req_ready_b, rsp_valid_b}, 2'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    set_flips(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {puf_rst_n, puf_vin_valid, rsp_valid, puf_c, rsp_resp, rsp_unstable, rsp_chal},
          64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_idle", {req_ready, puf_rst_n, puf_vin_valid}, 3'b110);

    // Stable PUF
    run_req(8'hA9, 0, 1'b0, 1'b0);
    // Bit 0 flipped on votes 2 and 4
    set_flips(8'h00, 8'h01, 8'h00, 8'h01, 8'h00);
    run_req(8'hA9, 0, 1'b0, 1'b0);
    // Bit 7 flipped on votes 1, 3 and 5
    set_flips(8'h80, 8'h00, 8'h80, 8'h00, 8'h80);
    run_req(8'hA9, 0, 1'b0, 1'b0);
    // Backpressure, then a second request
    set_flips(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    rsp_ready = 1'b0;
    run_req(8'hA9, 20, 1'b0, 1'b0);
    run_req(8'h00, 0, 1'b0, 1'b0);
    // Late request during vote 3 is ignored
    set_flips(8'h00, 8'h10, 8'h00, 8'h00, 8'h00);
    run_req(8'hA9, 0, 1'b1, 1'b0);
    // Abort in vote 4 SAMPLE with a noisy vote pending, then a clean run
    set_flips(8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00);
    run_req(8'h66, 0, 1'b0, 1'b1);
    set_flips(8'h00, 8'h00, 8'h00, 8'h04, 8'h00);
    run_req(8'h66, 0, 1'b0, 1'b0);

    // Single vote, single settle cycle
    run_b(8'hA9, 8'h00);
    run_b(8'h3C, 8'h81);
    run_b(8'hFF, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/puf_response_voter.md
# puf_response_voter

Majority-vote response stabiliser between the challenge source and the memristive PUF core (`PUF_FPGA`). It accepts one challenge per request and re-resets the PUF before each of `N_VOTE` evaluations. For each evaluation it applies the challenge, waits a fixed settle time and samples `R`. It then returns the per-bit majority response together with a mask of bits that were not unanimous. This is the stage that directly drives the PUF core's `rst_n`/`vin_valid`/`C` and consumes its `R`.

## Interface
- `N_CHAL`, 8, challenge width; equals PUF `N_CHAL`
- `N_RESP`, 8, response width; equals PUF `N_RESP`
- `N_VOTE`, 5, evaluations per challenge; odd, ≥1
- `SETTLE_CYC`, 16, cycles `puf_vin_valid` is held high before sampling; ≥1
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  challenge request valid
- `req_ready`  out  1  voter idle and able to accept
- `req_chal`  in  N_CHAL  challenge
- `puf_rst_n`  out  1  to PUF `rst_n`
- `puf_vin_valid`  out  1  to PUF `vin_valid`
- `puf_C`  out  N_CHAL  to PUF `C`
- `puf_R`  in  N_RESP  from PUF `R`
- `rsp_valid`  out  1  stabilised response valid
- `rsp_ready`  in  1  downstream accepts response
- `rsp_resp`  out  N_RESP  majority response
- `rsp_unstable`  out  N_RESP  bit i = 1 if the votes for bit i were not unanimous
- `rsp_chal`  out  N_CHAL  challenge echo for `rsp_resp`

## Operation
- FSM states: IDLE, PRST, APPLY, SAMPLE, DONE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid && req_ready`: latch `req_chal` into `chal_q`, clear all per-bit counters and the vote counter, then go to PRST.
  - Later changes on `req_chal` have no effect.
- PRST: `puf_rst_n`=0 and `puf_vin_valid`=0 for exactly 2 cycles, then APPLY.
- APPLY: `puf_rst_n`=1, `puf_vin_valid`=1, `puf_C`=`chal_q` for exactly `SETTLE_CYC` cycles, then SAMPLE.
- SAMPLE (1 cycle):
  - `puf_vin_valid` stays 1.
  - At the end of the cycle, `cnt1[i]` += `puf_R[i]` for every i, and the vote counter increments.
  - Next state is PRST if votes < `N_VOTE`, else DONE.
- DONE:
  - `rsp_valid`=1.
  - `rsp_resp[i]` = (`cnt1[i]` > `N_VOTE`/2).
  - `rsp_unstable[i]` = (`cnt1[i]`≠0 && `cnt1[i]`≠`N_VOTE`).
  - `rsp_chal`=`chal_q`.
  - `puf_rst_n`=1 and `puf_vin_valid`=0.
  - Outputs hold stable until `rsp_ready`; on `rsp_valid && rsp_ready`, go to IDLE.
- `puf_C` holds `chal_q` in every state except reset; it is 0 after reset until the first accept.
- Arithmetic: counters are `$clog2(N_VOTE+1)` bits and can never overflow. Majority is a strict greater-than against floor(`N_VOTE`/2); odd `N_VOTE` means no ties.
- `req_valid` outside IDLE is ignored; the requester must hold it, since nothing is queued.
- In IDLE, `puf_rst_n`=1 and `puf_vin_valid`=0.

## Timing
- Reset values (during and in the cycle after `rst`):
  - state IDLE, `req_ready`=1 once `rst` is low.
  - `puf_rst_n`=0 while `rst`=1.
  - `puf_vin_valid`=0, `puf_C`=0.
  - `rsp_valid`=0, `rsp_resp`=0, `rsp_unstable`=0, `rsp_chal`=0.
  - All counters 0.
- One vote = 2 + `SETTLE_CYC` + 1 cycles (19 at defaults).
- Accept at edge T: PRST covers cycles T..T+1 and `rsp_valid` first rises after edge T + `N_VOTE`·(`SETTLE_CYC`+3), i.e. 95 cycles at defaults.
- `rsp_ready` already high when `rsp_valid` rises: the handshake completes at the next edge and `req_ready`=1 the cycle after. Minimum request-to-request spacing is latency + 1 cycle.
- `rst` asserted in any state: abort at the next edge with no response produced, and all outputs go to reset values. A held request is re-accepted only after `rst` deasserts.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Stable PUF model `R = C ^ 8'h5A`, request `C=8'hA9` → after exactly 95 cycles `rsp_valid`=1, `rsp_resp`=8'hF3, `rsp_unstable`=8'h00, `rsp_chal`=8'hA9. Also check that `puf_rst_n` pulses low for 2 cycles before each of the 5 samples.
- Noisy model flipping bit 0 on votes 2 and 4 (1-based) → `rsp_resp`=8'hF3 and `rsp_unstable`=8'h01. Flipping bit 7 on votes 1, 3 and 5 → `rsp_resp`=8'h73 and `rsp_unstable`=8'h80.
- Backpressure: hold `rsp_ready`=0 for 20 cycles after `rsp_valid` → outputs stay constant and `req_ready`=0 throughout. Assert `rsp_ready` → IDLE, and a second request `C=8'h00` yields `rsp_resp`=8'h5A.
- Change `req_chal` and pulse `req_valid` during APPLY of vote 3 → request ignored, `puf_C` unchanged, response uses the original challenge.
- Assert `rst` for 1 cycle in SAMPLE of vote 4 → all outputs return to reset values and `rsp_valid` never rises. The next request completes normally with fresh counters, giving the correct majority.
- `N_VOTE=1`, `SETTLE_CYC=1` → latency 4 cycles, `rsp_unstable` is always 0, and `rsp_resp` equals the single sample.
